// File: rtl/mem_access_unit.sv
// Load/store unit between a requester and a word-wide data memory with alignment checks.
// Byte/halfword accesses (lane extract, sign extension, read-modify-write) exist only when LSU_SUBWORD_EN is defined.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  localparam logic [1:0] SIZE_W = 2'b10;
`ifdef LSU_SUBWORD_EN
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
`endif

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        req_legal;
  logic        req_rmw;
  logic [31:0] load_data;

  // Legality is decided on the raw request so an illegal one never touches memory.
  always_comb begin
    req_legal = 1'b0;
    req_rmw   = 1'b0;
    case (req_size)
      SIZE_W: req_legal = (req_addr[1:0] == 2'b00);
`ifdef LSU_SUBWORD_EN
      SIZE_H: begin
        req_legal = ~req_addr[0];
        req_rmw   = req_we;
      end
      SIZE_B: begin
        req_legal = 1'b1;
        req_rmw   = req_we;
      end
`endif
      default: req_legal = 1'b0;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  logic [31:0] lane_data;
  logic [31:0] merge_data;

  // Little-endian lane extract: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane_data = mem_dout >> {addr_q[1:0], 3'b000};
    load_data = mem_dout;
    case (size_q)
      SIZE_B:  load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      SIZE_H:  load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_data = mem_dout;
    endcase
  end

  always_comb begin
    merge_data = mem_dout;
    case (size_q)
      SIZE_B:  merge_data[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      SIZE_H:  merge_data[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merge_data = data_q;
    endcase
  end
`else
  logic unused_subword;

  assign load_data      = mem_dout;
  assign unused_subword = ^{size_q, signed_q, addr_q[1:0]};
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          data_d   = req_wdata;
          err_d    = ~req_legal;
          if (!req_legal) begin
            state_d = RESP;
          end else if (!req_we || req_rmw) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: state_d = RDW;
      RDW: begin
`ifdef LSU_SUBWORD_EN
        if (we_q) begin
          data_d  = merge_data;
          state_d = WR;
        end else begin
          data_d  = load_data;
          state_d = RESP;
        end
`else
        data_d  = load_data;
        state_d = RESP;
`endif
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Strobes are gated by reset so an abort suppresses a write already in flight.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_ren   = (state_q == RD) && !reset;
    mem_wen   = (state_q == WR) && !reset;
    mem_addr  = (mem_ren || mem_wen) ? {addr_q[9:2], 2'b00} : '0;
    mem_din   = mem_wen ? data_q : '0;
    rsp_valid = (state_q == RESP) && !reset;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? data_q : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-addressed reference memory feeding a response scoreboard.
// Expectations follow the LSU_SUBWORD_EN setting of the build.
module tb_mem_access_unit;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rens;
    int          wens;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen;
  logic        mem_ren;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:255];
  logic [7:0]  shadow [0:1023];
  exp_t        sb [$];

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int addr_bad_cnt = 0;
  int leak_cnt = 0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data memory: read data appears the cycle after mem_ren is sampled.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_din;
    if (mem_ren) mem_dout <= mem[mem_addr[9:2]];
  end

  always @(negedge clk) begin
    if (mem_ren && mem_wen) overlap_cnt++;
    if ((mem_ren || mem_wen) && (mem_addr[1:0] != 2'b00)) addr_bad_cnt++;
    if (!rsp_valid && (rsp_rdata != 32'h0)) leak_cnt++;
  end

  task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [9:0] addr, input logic [31:0] wdata, output exp_t e);
    int n;
    bit legal;
    logic [31:0] v;
    case (size)
      SZ_B:    n = 1;
      SZ_H:    n = 2;
      SZ_W:    n = 4;
      default: n = 0;
    endcase
`ifndef LSU_SUBWORD_EN
    if (n != 4) n = 0;
`endif
    legal = 1'b0;
    if (n != 0) legal = ((int'(addr) % n) == 0);
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.lat   = 0;
    e.rens  = 0;
    e.wens  = 0;
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) shadow[int'(addr) + i] = wdata[8*i +: 8];
      e.wens = 1;
      e.rens = (n == 4) ? 0 : 1;
      e.lat  = (n == 4) ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < n) v[8*i +: 8] = shadow[int'(addr) + i];
        else if (sgn && shadow[int'(addr) + n - 1][7]) v[8*i +: 8] = 8'hFF;
      end
      e.rdata = v;
      e.rens  = 1;
      e.lat   = 3;
    end
  endtask

  task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wdata);
    exp_t e;
    int cyc;
    int rens;
    int wens;
    int early_ready;
    bit got;
    logic [31:0] got_rdata;
    logic got_err;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    model_req(we, size, sgn, addr, wdata, e);
    sb.push_back(e);
    cyc = 0; rens = 0; wens = 0; early_ready = 0; got = 1'b0;
    got_rdata = '0; got_err = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = ~sgn;
        req_addr   = 10'($urandom);
        req_wdata  = $urandom;
      end
      if (mem_ren) rens++;
      if (mem_wen) wens++;
      if (!rsp_valid && req_ready) early_ready++;
      if (rsp_valid) begin
        got       = 1'b1;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s timeout: no rsp_valid within %0d cycles", name, cyc);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks += 5;
      if (cyc != e.lat) begin
        errors++; $display("[TB] FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
      end
      if (got_rdata !== e.rdata) begin
        errors++; $display("[TB] FAIL %s rdata: got %h want %h", name, got_rdata, e.rdata);
      end
      if (got_err !== e.err) begin
        errors++; $display("[TB] FAIL %s err: got %b want %b", name, got_err, e.err);
      end
      if (rens != e.rens) begin
        errors++; $display("[TB] FAIL %s mem_ren pulses: got %0d want %0d", name, rens, e.rens);
      end
      if (wens != e.wens) begin
        errors++; $display("[TB] FAIL %s mem_wen pulses: got %0d want %0d", name, wens, e.wens);
      end
    end
    checks++;
    if (early_ready != 0) begin
      errors++; $display("[TB] FAIL %s busy_ready: got %0d cycles want 0", name, early_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset req_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset rsp_err: got %b want 0", rsp_err); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
    if (mem_wen !== 1'b0)   begin errors++; $display("[TB] FAIL reset mem_wen: got %b want 0", mem_wen); end
    if (mem_ren !== 1'b0)   begin errors++; $display("[TB] FAIL reset mem_ren: got %b want 0", mem_ren); end
    if (mem_addr !== 10'h0) begin errors++; $display("[TB] FAIL reset mem_addr: got %h want 0", mem_addr); end
    if (mem_din !== 32'h0)  begin errors++; $display("[TB] FAIL reset mem_din: got %h want 0", mem_din); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    do_req("word_st12", 1'b1, SZ_W, 1'b0, 10'd12, 32'hDEADBEEF);
    do_req("word_ld12", 1'b0, SZ_W, 1'b0, 10'd12, 32'h0);
  endtask

  task automatic test_byte_store();
    do_req("word_st100", 1'b1, SZ_W, 1'b0, 10'd100, 32'h12345678);
    do_req("byte_st101", 1'b1, SZ_B, 1'b0, 10'd101, 32'h000000AB);
    do_req("word_ld100", 1'b0, SZ_W, 1'b0, 10'd100, 32'h0);
    do_req("half_st102", 1'b1, SZ_H, 1'b0, 10'd102, 32'h0000CDEF);
    do_req("word_ld100b", 1'b0, SZ_W, 1'b0, 10'd100, 32'h0);
  endtask

  task automatic test_sign_ext();
    do_req("word_st200", 1'b1, SZ_W, 1'b0, 10'd200, 32'h80FF7F01);
    do_req("sbyte_ld202", 1'b0, SZ_B, 1'b1, 10'd202, 32'h0);
    do_req("uhalf_ld202", 1'b0, SZ_H, 1'b0, 10'd202, 32'h0);
    do_req("sbyte_ld200", 1'b0, SZ_B, 1'b1, 10'd200, 32'h0);
    do_req("shalf_ld202", 1'b0, SZ_H, 1'b1, 10'd202, 32'h0);
    do_req("ubyte_ld203", 1'b0, SZ_B, 1'b0, 10'd203, 32'h0);
    do_req("shalf_ld200", 1'b0, SZ_H, 1'b1, 10'd200, 32'h0);
  endtask

  task automatic test_misaligned();
    do_req("word_ld13", 1'b0, SZ_W, 1'b0, 10'd13, 32'h0);
    do_req("half_st101", 1'b1, SZ_H, 1'b0, 10'd101, 32'h0000FFFF);
    do_req("size11_ld", 1'b0, SZ_X, 1'b0, 10'd100, 32'h0);
    do_req("word_st102", 1'b1, SZ_W, 1'b0, 10'd102, 32'hFFFFFFFF);
    do_req("word_ld100c", 1'b0, SZ_W, 1'b0, 10'd100, 32'h0);
  endtask

  task automatic test_reset_abort();
    int stray;
    do_req("rst_init40", 1'b1, SZ_W, 1'b0, 10'd40, 32'h11223344);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_signed = 1'b0;
    req_addr   = 10'd40;
    req_wdata  = 32'h000000AA;
`ifdef LSU_SUBWORD_EN
    req_size = SZ_B;
    repeat (2) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
`else
    req_size = SZ_W;
    @(negedge clk);
    req_valid = 1'b0;
`endif
    reset = 1'b1;
    #1;
    checks += 2;
    if (mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL abort mem_wen: got %b want 0", mem_wen); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort rsp_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || mem_wen) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("[TB] FAIL abort stray: got %0d cycles want 0", stray); end
    do_req("rst_ld40", 1'b0, SZ_W, 1'b0, 10'd40, 32'h0);
  endtask

  task automatic test_no_subword();
    do_req("word_st8", 1'b1, SZ_W, 1'b0, 10'd8, 32'hA5C3_0F96);
    do_req("byte_ld8", 1'b0, SZ_B, 1'b0, 10'd8, 32'h0);
    do_req("word_ld8", 1'b0, SZ_W, 1'b0, 10'd8, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [9:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 10'(300 + 4 * k);
      do_req("b2b_init", 1'b1, SZ_W, 1'b0, a, $urandom);
    end
    for (int i = 0; i < 10; i++) begin
      a = 10'(300 + 4 * $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_req("b2b_st", 1'b1, SZ_W, 1'b0, a, $urandom);
      else                           do_req("b2b_ld", 1'b0, SZ_W, 1'b0, a, 32'h0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    test_reset();
    test_word();
    test_byte_store();
    test_sign_ext();
    test_misaligned();
    test_reset_abort();
    test_no_subword();
    test_back_to_back();
    checks += 3;
    if (overlap_cnt != 0) begin errors++; $display("[TB] FAIL ren_wen_overlap: got %0d want 0", overlap_cnt); end
    if (addr_bad_cnt != 0) begin errors++; $display("[TB] FAIL mem_addr_align: got %0d want 0", addr_bad_cnt); end
    if (leak_cnt != 0) begin errors++; $display("[TB] FAIL rdata_idle_zero: got %0d want 0", leak_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
